tri_port_memory: RTL and testbench
==================================

TRI_PORT_MEMORY -- requirements
Module: tri_port_memory

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, byte-address width; capacity 2^ADDRESS_WIDTH bytes.
REQ-002 SHALL have port clock_in  input  1  single clock for all ports.
REQ-003 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port write_data_in  input  32  write data, right-justified for byte/half.
REQ-005 SHALL have port write_address_in  input  ADDRESS_WIDTH  write byte address.
REQ-006 SHALL have port read_address_0_in  input  ADDRESS_WIDTH  read port 0 byte address.
REQ-007 SHALL have port read_address_1_in  input  ADDRESS_WIDTH  read port 1 byte address.
REQ-008 SHALL have port write_in  input  1  write enable.
REQ-009 SHALL have port memMode_in  input  2  write size: 00 word, 10 half, 11 byte, 01 treated as word.
REQ-010 SHALL have port read_data_0_out  output  32  read port 0 word.
REQ-011 SHALL have port read_data_1_out  output  32  read port 1 word.

Function
REQ-012 SHALL store a byte-addressed array; all multi-byte accesses big-endian, lowest address = most significant byte.
REQ-013 SHALL support unaligned accesses at any address; byte addresses SHALL wrap modulo 2^ADDRESS_WIDTH (e.g. word at 0xFF covers 0xFF,0x00,0x01,0x02).
REQ-014 SHALL write on rising clock_in edge when write_in=1: word mode writes 4 bytes of write_data_in[31:0]; half mode writes 2 bytes of [15:0]; byte mode writes 1 byte [7:0]; other bytes unchanged.
REQ-015 SHALL ignore write_data_in, write_address_in, memMode_in when write_in=0.
REQ-016 SHALL always read a full 32-bit word per port regardless of memMode_in (mode affects writes only).
REQ-017 SHALL register both read outputs on falling clock_in edge from current array contents at addr..addr+3.
REQ-018 SHALL make a rising-edge write visible on a same-address read at the immediately following falling edge (half-cycle write-to-read latency).
REQ-019 SHALL serve both read ports independently; identical or overlapping read and write addresses SHALL be legal.

Reset
REQ-020 SHALL, while reset_in=1, asynchronously force read_data_0_out and read_data_1_out to 32'h0 and block writes.
REQ-021 SHALL resume normal operation at the first clock edge after reset_in deasserts; reset mid-write SHALL suppress that write.

Configuration
REQ-022 SHALL, with TPM_RESET_CLEAR_EN defined, clear every array byte to 8'h00 asynchronously on reset.
REQ-023 SHALL, without TPM_RESET_CLEAR_EN, leave array contents unchanged by reset (outputs still reset per REQ-020).

Structure
REQ-024 SHALL place DATA_WIDTH=32 and enum mem_mode_t (MEM_WORD=2'b00, MEM_HALF=2'b10, MEM_BYTE=2'b11) in package tpm_pkg.
REQ-025 SHALL implement word assembly (4 wrapped byte reads, big-endian concatenation) in sub-module tpm_word_reader, instantiated once per read port.

Verification
REQ-026 Word write 0x00000001 @0x00, read port0 @0x00 -> read_data_0_out=0x00000001 at next falling edge.
REQ-027 Then word write 0xFFFF0F05 @0xFF (wrap) -> read @0xFF = 0xFFFF0F05, read @0x00 = 0xFF0F0501.
REQ-028 Byte writes 0xFFFFABAB@0x1C, 0x1F7FCD00@0x1D, 0x4321FAB0@0x1E, 0x8197F11B@0x1F -> read @0x1C = 0xAB00B01B.
REQ-029 Half writes 0x1234ABCD@0x19 then 0xF00F0FF0@0x1A (after REQ-028) -> read @0x19 = 0xAB0FF0AB; port1 @0x19 simultaneously same value.
REQ-030 write_in=0 with data 0xDEADBEEF @0x00 -> read @0x00 unchanged.
REQ-031 Assert reset_in mid-cycle -> both outputs 0 immediately; with TPM_RESET_CLEAR_EN, post-reset read @0x1C = 0x00000000, without it = 0xAB0FF0AB... (pre-reset contents).

Source files
------------

// File: rtl/tpm_pkg.sv
// Shared types and constants for the tri-port byte-addressed memory.
package tpm_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_HALF = 2'b10,
        MEM_BYTE = 2'b11
    } mem_mode_t;

    // Encoding 2'b01 is not a named mode and behaves as a word write.
    function automatic int unsigned mode_bytes(input logic [1:0] mode);
        case (mode)
            MEM_HALF: return 2;
            MEM_BYTE: return 1;
            default:  return BYTES_PER_WORD;
        endcase
    endfunction

endpackage

// File: rtl/tpm_word_reader.sv
// Assembles one big-endian 32-bit word from four consecutive bytes of the
// array, with the byte address wrapping at the top of the address space.
module tpm_word_reader
    import tpm_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic [7:0]               mem [2**ADDRESS_WIDTH],
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    word
);

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            word[DATA_WIDTH-1-8*i -: 8] = mem[address + ADDRESS_WIDTH'(i)];
        end
    end

endmodule

// File: rtl/tri_port_memory.sv
// Byte-addressed memory: one write port (word/half/byte, big-endian) and two
// falling-edge registered word read ports. Define TPM_RESET_CLEAR_EN to clear the array on reset.
module tri_port_memory
    import tpm_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [DATA_WIDTH-1:0]    write_data_in,
    input  logic [ADDRESS_WIDTH-1:0] write_address_in,
    input  logic [ADDRESS_WIDTH-1:0] read_address_0_in,
    input  logic [ADDRESS_WIDTH-1:0] read_address_1_in,
    input  logic                     write_in,
    input  logic [1:0]               memMode_in,
    output logic [DATA_WIDTH-1:0]    read_data_0_out,
    output logic [DATA_WIDTH-1:0]    read_data_1_out
);

    localparam int unsigned DEPTH = 2**ADDRESS_WIDTH;

    logic [7:0]               mem [DEPTH];
    int unsigned              write_bytes;
    logic                     byte_we   [BYTES_PER_WORD];
    logic [ADDRESS_WIDTH-1:0] byte_addr [BYTES_PER_WORD];
    logic [7:0]               byte_data [BYTES_PER_WORD];
    logic [DATA_WIDTH-1:0]    word_0;
    logic [DATA_WIDTH-1:0]    word_1;

    // Lane k targets address+k and takes the k-th most significant byte of the
    // right-justified write field, so the lowest address gets the MSB.
    always_comb begin
        write_bytes = mode_bytes(memMode_in);
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            byte_we[k]   = write_in && (k < write_bytes);
            byte_addr[k] = write_address_in + ADDRESS_WIDTH'(k);
            byte_data[k] = '0;
            if (k < write_bytes) begin
                byte_data[k] = write_data_in[8*(write_bytes-1-k) +: 8];
            end
        end
    end

`ifdef TPM_RESET_CLEAR_EN
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                if (byte_we[k]) begin
                    mem[byte_addr[k]] <= byte_data[k];
                end
            end
        end
    end
`else
    // Contents survive reset; reset only blocks the write.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                if (byte_we[k]) begin
                    mem[byte_addr[k]] <= byte_data[k];
                end
            end
        end
    end
`endif

    tpm_word_reader #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_reader_0 (
        .mem     (mem),
        .address (read_address_0_in),
        .word    (word_0)
    );

    tpm_word_reader #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_reader_1 (
        .mem     (mem),
        .address (read_address_1_in),
        .word    (word_1)
    );

    // Falling-edge capture gives half-cycle visibility of a rising-edge write.
    always_ff @(negedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            read_data_0_out <= '0;
            read_data_1_out <= '0;
        end else begin
            read_data_0_out <= word_0;
            read_data_1_out <= word_1;
        end
    end

endmodule

// File: tb/tb_tri_port_memory.sv
// Self-checking bench for tri_port_memory: directed vector table, randomized
// traffic against a byte-array model, and mid-cycle reset handling.
module tb_tri_port_memory;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b0;
    logic [31:0]   write_data_in = '0;
    logic [AW-1:0] write_address_in = '0;
    logic [AW-1:0] read_address_0_in = '0;
    logic [AW-1:0] read_address_1_in = '0;
    logic          write_in = 1'b0;
    logic [1:0]    memMode_in = 2'b00;
    logic [31:0]   read_data_0_out;
    logic [31:0]   read_data_1_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        logic          we;
        logic [1:0]    mode;
        logic [31:0]   data;
        logic [AW-1:0] waddr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   exp0;
        logic [31:0]   exp1;
    } vec_t;

    vec_t vecs [12];

    tri_port_memory #(.ADDRESS_WIDTH(AW)) dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .write_data_in     (write_data_in),
        .write_address_in  (write_address_in),
        .read_address_0_in (read_address_0_in),
        .read_address_1_in (read_address_1_in),
        .write_in          (write_in),
        .memMode_in        (memMode_in),
        .read_data_0_out   (read_data_0_out),
        .read_data_1_out   (read_data_1_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic void model_write(input logic we, input logic [1:0] mode,
                                        input logic [31:0] data, input logic [AW-1:0] addr);
        int unsigned n;
        if (!we) return;
        n = (mode == 2'b10) ? 2 : (mode == 2'b11) ? 1 : 4;
        for (int unsigned j = 0; j < n; j++)
            ref_mem[(int'(addr) + j) % DEPTH] = 8'(data >> (8 * (n - 1 - j)));
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
        logic [31:0] r = '0;
        for (int unsigned j = 0; j < 4; j++)
            r = {r[23:0], ref_mem[(int'(addr) + j) % DEPTH]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive after a falling edge; the write lands at the next rising edge and
    // the read result is sampled just after the following falling edge.
    task automatic step(input logic we, input logic [1:0] mode, input logic [31:0] data,
                        input logic [AW-1:0] waddr, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        write_in          = we;
        memMode_in        = mode;
        write_data_in     = data;
        write_address_in  = waddr;
        read_address_0_in = a0;
        read_address_1_in = a1;
        @(posedge clock_in);
        @(negedge clock_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 32'h00000001, 8'h00, 8'h00, 8'h00, 32'h00000001, 32'h00000001};
        vecs[1]  = '{1'b1, 2'b00, 32'hFFFF0F05, 8'hFF, 8'hFF, 8'h00, 32'hFFFF0F05, 32'hFF0F0501};
        vecs[2]  = '{1'b1, 2'b11, 32'hFFFFABAB, 8'h1C, 8'h1C, 8'h00, 32'hAB1D1E1F, 32'hFF0F0501};
        vecs[3]  = '{1'b1, 2'b11, 32'h1F7FCD00, 8'h1D, 8'h1C, 8'h00, 32'hAB001E1F, 32'hFF0F0501};
        vecs[4]  = '{1'b1, 2'b11, 32'h4321FAB0, 8'h1E, 8'h1C, 8'h00, 32'hAB00B01F, 32'hFF0F0501};
        vecs[5]  = '{1'b1, 2'b11, 32'h8197F11B, 8'h1F, 8'h1C, 8'h00, 32'hAB00B01B, 32'hFF0F0501};
        vecs[6]  = '{1'b1, 2'b10, 32'h1234ABCD, 8'h19, 8'h19, 8'h1C, 32'hABCD1BAB, 32'hAB00B01B};
        vecs[7]  = '{1'b1, 2'b10, 32'hF00F0FF0, 8'h1A, 8'h19, 8'h19, 32'hAB0FF0AB, 32'hAB0FF0AB};
        vecs[8]  = '{1'b0, 2'b00, 32'hDEADBEEF, 8'h00, 8'h00, 8'hFF, 32'hFF0F0501, 32'hFFFF0F05};
        vecs[9]  = '{1'b1, 2'b01, 32'h11223344, 8'h40, 8'h40, 8'h3F, 32'h11223344, 32'h3F112233};
        vecs[10] = '{1'b1, 2'b10, 32'h0000A5C3, 8'hFF, 8'hFF, 8'hFE, 32'hA5C30F05, 32'hFEA5C30F};
        vecs[11] = '{1'b0, 2'b11, 32'h000000EE, 8'h1C, 8'h1C, 8'h1A, 32'hAB00B01B, 32'h0FF0AB00};

        // Reset with the clock running: outputs held at zero.
        #1 reset_in = 1'b1;
        repeat (2) @(negedge clock_in);
        #1;
        check("reset_p0", read_data_0_out, 32'h0);
        check("reset_p1", read_data_1_out, 32'h0);
        reset_in = 1'b0;

        // Fill: byte at address b holds value b.
        for (int unsigned i = 0; i < DEPTH / 4; i++) begin
            logic [31:0] w;
            w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            step(1'b1, 2'b00, w, 8'(4*i), 8'h00, 8'h00);
            model_write(1'b1, 2'b00, w, 8'(4*i));
        end

        for (int unsigned i = 0; i < 12; i++) begin
            step(vecs[i].we, vecs[i].mode, vecs[i].data, vecs[i].waddr, vecs[i].ra0, vecs[i].ra1);
            model_write(vecs[i].we, vecs[i].mode, vecs[i].data, vecs[i].waddr);
            check($sformatf("vec%0d_p0", i), read_data_0_out, vecs[i].exp0);
            check($sformatf("vec%0d_p1", i), read_data_1_out, vecs[i].exp1);
        end

        for (int unsigned i = 0; i < 400; i++) begin
            logic          we;
            logic [1:0]    mode;
            logic [31:0]   data;
            logic [AW-1:0] wa, a0, a1;
            we   = 1'($urandom_range(0, 3) != 0);
            mode = 2'($urandom);
            data = $urandom;
            wa   = 8'($urandom);
            a0   = ($urandom_range(0, 1) == 1) ? wa : 8'($urandom);
            a1   = wa + 8'($urandom_range(0, 6)) - 8'd3;
            step(we, mode, data, wa, a0, a1);
            model_write(we, mode, data, wa);
            check($sformatf("rand%0d_p0", i), read_data_0_out, model_read(a0));
            check($sformatf("rand%0d_p1", i), read_data_1_out, model_read(a1));
        end

        // Known nonzero contents before the mid-cycle reset.
        step(1'b1, 2'b00, 32'hAB0FF0AB, 8'h1C, 8'h1C, 8'h1C);
        model_write(1'b1, 2'b00, 32'hAB0FF0AB, 8'h1C);
        check("prereset_p0", read_data_0_out, 32'hAB0FF0AB);

        #2;
        reset_in         = 1'b1;
        write_in         = 1'b1;
        memMode_in       = 2'b00;
        write_data_in    = 32'hDEADBEEF;
        write_address_in = 8'h1C;
        #1;
        check("rst_async_p0", read_data_0_out, 32'h0);
        check("rst_async_p1", read_data_1_out, 32'h0);
        @(posedge clock_in);
        @(negedge clock_in);
        #1;
        check("rst_hold_p0", read_data_0_out, 32'h0);
        check("rst_hold_p1", read_data_1_out, 32'h0);
`ifdef TPM_RESET_CLEAR_EN
        for (int unsigned j = 0; j < DEPTH; j++) ref_mem[j] = 8'h00;
`endif
        reset_in = 1'b0;
        step(1'b0, 2'b00, 32'h0, 8'h00, 8'h1C, 8'h80);
        check("postrst_p0", read_data_0_out, model_read(8'h1C));
        check("postrst_p1", read_data_1_out, model_read(8'h80));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
